// File: rtl/hls_deadlock_monitor_unit.sv
// Per-process deadlock monitor for an HLS dataflow region: merges upstream dependence
// vectors, declares deadlock after persistent self-dependence, and forwards the report token.
module hls_deadlock_monitor_unit #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int PERSIST_CYCLES = 4,
  parameter int CNT_W          = 8,
  parameter int TOKEN_RR       = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            dl_report_valid,
  output logic [PROC_NUM-1:0]             dl_report_dep,
  output logic [CNT_W-1:0]                dl_stall_cnt,
  output logic [1:0]                      dbg_state
);

  localparam int PTR_W = (OUT_CHAN_NUM > 1) ? $clog2(OUT_CHAN_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    DETECTED = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        stall_q;
  logic [PROC_NUM-1:0]     dep_reg_q;
  logic [PROC_NUM-1:0]     report_dep_q;
  logic                    report_valid_q;
  logic                    detect_q;
  logic [OUT_CHAN_NUM-1:0] token_q;
  logic [PTR_W-1:0]        rr_ptr_q;

  logic [PROC_NUM-1:0]     merged;
  logic [PROC_NUM-1:0]     dep_sel;
  logic                    gate;
  logic                    any_blk;
  logic                    self_dep;
  logic                    load;
  logic [OUT_CHAN_NUM-1:0] cand;
  logic [PTR_W-1:0]        cand_idx;
  logic                    found;

  always_comb begin
    merged = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      merged = merged | ({PROC_NUM{in_chan_dep_vld_vec[i]}} &
                         in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM]);
    end
  end

  // Upstream vectors are only trusted while no global deadlock is flagged, unless a token arrives.
  assign gate     = ~dl_detect_in | (|token_in_vec);
  assign dep_sel  = gate ? merged : dep_reg_q;
  assign any_blk  = |proc_dep_vld_vec;
  assign self_dep = gate & dep_sel[PROC_ID] & any_blk;
  assign load     = ((|token_in_vec) & ~token_clear) | origin;

  always_comb begin
    cand_idx = '0;
    found    = 1'b0;
    if (TOKEN_RR == 0) begin
      for (int k = 0; k < OUT_CHAN_NUM; k++) begin
        if (proc_dep_vld_vec[k]) cand_idx = PTR_W'(k);
      end
    end else begin
      // Scan starts just after the last grant and wraps, so the last grantee is tried last.
      for (int s = 1; s <= OUT_CHAN_NUM; s++) begin
        if (!found && proc_dep_vld_vec[(int'(rr_ptr_q) + s) % OUT_CHAN_NUM]) begin
          found    = 1'b1;
          cand_idx = PTR_W'((int'(rr_ptr_q) + s) % OUT_CHAN_NUM);
        end
      end
    end
    cand           = '0;
    cand[cand_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_q        <= '0;
      dep_reg_q      <= '0;
      report_dep_q   <= '0;
      report_valid_q <= 1'b0;
      detect_q       <= 1'b0;
      token_q        <= '0;
      rr_ptr_q       <= '0;
    end else begin
      dep_reg_q <= any_blk ? dep_sel : '0;

      if (!any_blk) stall_q <= '0;
      else if (stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;

      if (load) begin
        token_q  <= cand;
        rr_ptr_q <= cand_idx;
      end else begin
        token_q  <= '0;
      end

      if (token_clear) begin
        state_q        <= IDLE;
        cnt_q          <= '0;
        report_valid_q <= 1'b0;
        detect_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (self_dep) begin
              if (PERSIST_CYCLES == 1) begin
                state_q        <= DETECTED;
                detect_q       <= 1'b1;
                report_dep_q   <= dep_sel;
                report_valid_q <= 1'b1;
              end else begin
                state_q <= ARM;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
          ARM: begin
            if (!self_dep) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q + 1'b1 == CNT_W'(PERSIST_CYCLES)) begin
              state_q        <= DETECTED;
              detect_q       <= 1'b1;
              report_dep_q   <= dep_sel;
              report_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DETECTED: begin
            state_q <= DETECTED;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg_q | (PROC_NUM'(1) << PROC_ID);
  assign token_out_vec        = token_q;
  assign dl_detect_out        = detect_q;
  assign dl_report_valid      = report_valid_q;
  assign dl_report_dep        = report_dep_q;
  assign dl_stall_cnt         = stall_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_unit.sv
// Bench for hls_deadlock_monitor_unit: two instances (fixed-priority token / 8-bit counter and
// round-robin token / 3-bit counter) share stimulus and are checked against a behavioural model.
module tb_hls_deadlock_monitor_unit;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] proc;
  logic [1:0] ivld;
  logic [7:0] idata;
  logic [1:0] tok_in;
  logic       dl_in, org, clr;

  logic [2:0] a_vld, a_tok, b_vld, b_tok;
  logic [3:0] a_data, a_rdep, b_data, b_rdep;
  logic       a_det, a_rv, b_det, b_rv;
  logic [7:0] a_stall;
  logic [2:0] b_stall;
  logic [1:0] a_st, b_st;

  hls_deadlock_monitor_unit #(.TOKEN_RR(0), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .proc_dep_vld_vec(proc), .in_chan_dep_vld_vec(ivld),
    .in_chan_dep_data_vec(idata), .token_in_vec(tok_in), .dl_detect_in(dl_in), .origin(org),
    .token_clear(clr), .out_chan_dep_vld_vec(a_vld), .out_chan_dep_data(a_data),
    .token_out_vec(a_tok), .dl_detect_out(a_det), .dl_report_valid(a_rv),
    .dl_report_dep(a_rdep), .dl_stall_cnt(a_stall), .dbg_state(a_st));

  hls_deadlock_monitor_unit #(.TOKEN_RR(1), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .proc_dep_vld_vec(proc), .in_chan_dep_vld_vec(ivld),
    .in_chan_dep_data_vec(idata), .token_in_vec(tok_in), .dl_detect_in(dl_in), .origin(org),
    .token_clear(clr), .out_chan_dep_vld_vec(b_vld), .out_chan_dep_data(b_data),
    .token_out_vec(b_tok), .dl_detect_out(b_det), .dl_report_valid(b_rv),
    .dl_report_dep(b_rdep), .dl_stall_cnt(b_stall), .dbg_state(b_st));

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int P = 4;
  bit [3:0] m_dep, m_rdep;
  bit       m_det, m_rv;
  int       m_run, m_stall, m_rr;
  bit [2:0] m_tok_a, m_tok_b;

  task automatic m_reset();
    m_dep = 0; m_rdep = 0; m_det = 0; m_rv = 0; m_run = 0; m_stall = 0; m_rr = 0;
    m_tok_a = 0; m_tok_b = 0;
  endtask

  task automatic m_step();
    bit [3:0] merged, sel;
    bit       gate, any, self;
    merged = 0;
    for (int i = 0; i < 2; i++) if (ivld[i]) merged |= idata[i*4 +: 4];
    gate = !dl_in || (tok_in != 0);
    sel  = gate ? merged : m_dep;
    any  = (proc != 0);
    self = gate && sel[0] && any;
    if (clr) begin
      m_run = 0; m_det = 0; m_rv = 0;
    end else if (!m_det) begin
      if (self) begin
        m_run++;
        if (m_run == P) begin m_det = 1; m_rv = 1; m_rdep = sel; end
      end else m_run = 0;
    end
    m_dep   = any ? sel : 4'd0;
    m_stall = any ? m_stall + 1 : 0;
    if (((tok_in != 0) && !clr) || org) begin
      int hi, nx;
      hi = 0;
      for (int k = 0; k < 3; k++) if (proc[k]) hi = k;
      m_tok_a = 3'(1 << hi);
      nx = 0;
      for (int s = 3; s >= 1; s--) if (proc[(m_rr + s) % 3]) nx = (m_rr + s) % 3;
      m_rr    = nx;
      m_tok_b = 3'(1 << nx);
    end else begin
      m_tok_a = 0; m_tok_b = 0;
    end
  endtask

  task automatic check_all();
    chk("a_vld", a_vld, proc);
    chk("a_data", a_data, m_dep | 4'b0001);
    chk("a_tok", a_tok, m_tok_a);
    chk("a_det", a_det, m_det);
    chk("a_rv", a_rv, m_rv);
    if (m_rv) chk("a_rdep", a_rdep, m_rdep);
    chk("a_stall", a_stall, (m_stall > 255) ? 255 : m_stall);
    chk("b_tok", b_tok, m_tok_b);
    chk("b_det", b_det, m_det);
    chk("b_stall", b_stall, (m_stall > 7) ? 7 : m_stall);
    chk("b_data", b_data, m_dep | 4'b0001);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [2:0] p, input logic [1:0] v, input logic [7:0] d,
                        input logic [1:0] t, input logic dl, input logic o, input logic c);
    proc = p; ivld = v; idata = d; tok_in = t; dl_in = dl; org = o; clr = c;
  endtask

  task automatic tick();
    @(posedge clock);
    m_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic self_cycle(input logic c);
    set_in(3'b001, 2'b01, 8'h01, 0, 0, 0, c);
    tick();
  endtask

  task automatic idle_cycle();
    set_in(3'b001, 2'b00, 8'h00, 0, 0, 0, 0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tok"}, {a_tok, b_tok}, 0);
    chk({tag, "_det"}, {a_det, b_det}, 0);
    chk({tag, "_rv"}, {a_rv, b_rv}, 0);
    chk({tag, "_rdep"}, {a_rdep, b_rdep}, 0);
    chk({tag, "_stall"}, {a_stall, 5'd0, b_stall}, 0);
    chk({tag, "_data"}, a_data, 4'b0001);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] p; logic [1:0] v; logic [7:0] d; logic o; logic c;
    logic e_det; logic e_rv; logic [2:0] e_tok_a; logic [2:0] e_tok_b;
  } vec_t;
  vec_t tbl[10];

  logic [31:0] exp_stall[$];

  initial begin
    // T1: self-dependence held; detect on 4th edge
    tbl[0] = '{3'b001, 2'b01, 8'h01, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[1] = '{3'b001, 2'b01, 8'h01, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[2] = '{3'b001, 2'b01, 8'h01, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[3] = '{3'b001, 2'b01, 8'h01, 0, 0, 1, 1, 3'b000, 3'b000};
    tbl[4] = '{3'b001, 2'b01, 8'h01, 0, 1, 0, 0, 3'b000, 3'b000};
    // T4: origin pulses with all channels blocked
    tbl[5] = '{3'b111, 2'b00, 8'h00, 1, 0, 0, 0, 3'b100, 3'b010};
    tbl[6] = '{3'b111, 2'b00, 8'h00, 1, 0, 0, 0, 3'b100, 3'b100};
    tbl[7] = '{3'b111, 2'b00, 8'h00, 1, 0, 0, 0, 3'b100, 3'b001};
    tbl[8] = '{3'b111, 2'b00, 8'h00, 1, 0, 0, 0, 3'b100, 3'b010};
    tbl[9] = '{3'b111, 2'b00, 8'h00, 0, 0, 0, 0, 3'b000, 3'b000};

    set_in(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #1;
    check_zero("reset");
    do_reset();
    check_zero("post_reset");

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].p, tbl[i].v, tbl[i].d, 0, 0, tbl[i].o, tbl[i].c);
      tick();
      chk($sformatf("tbl%0d_det", i), a_det, tbl[i].e_det);
      chk($sformatf("tbl%0d_rv", i), b_rv, tbl[i].e_rv);
      chk($sformatf("tbl%0d_tok_a", i), a_tok, tbl[i].e_tok_a);
      chk($sformatf("tbl%0d_tok_b", i), b_tok, tbl[i].e_tok_b);
      if (i == 3) chk("t1_rdep", a_rdep, 4'b0001);
    end

    // T2: burst of 3, gap, burst of 4
    do_reset();
    for (int i = 0; i < 3; i++) begin self_cycle(0); chk("t2_burst1", a_det, 0); end
    idle_cycle();
    chk("t2_gap", a_det, 0);
    for (int i = 0; i < 4; i++) begin self_cycle(0); chk("t2_burst2", a_det, (i == 3)); end

    // T3: clear while self-dependence persists, then re-detect
    self_cycle(1);
    chk("t3_clr_det", a_det, 0);
    chk("t3_clr_rv", a_rv, 0);
    for (int i = 0; i < 4; i++) begin self_cycle(0); chk("t3_redet", b_det, (i == 3)); end

    // T5: stall counter saturation
    do_reset();
    for (int i = 0; i < 10; i++) exp_stall.push_back((i + 1 > 7) ? 7 : i + 1);
    for (int i = 0; i < 10; i++) begin
      set_in(3'b111, 0, 0, 0, 0, 0, 0);
      tick();
      chk("t5_sat", b_stall, exp_stall.pop_front());
      chk("t5_wide", a_stall, i + 1);
    end
    set_in(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_drop", {a_stall, b_stall}, 0);

    // T6: asynchronous reset in ARM and in DETECTED
    do_reset();
    self_cycle(0);
    self_cycle(0);
    chk("t6_arm", a_st, 2'd1);
    #2 reset = 1'b0;
    #1 check_zero("t6_arm_rst");
    m_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) self_cycle(0);
    set_in(3'b011, 2'b01, 8'h01, 0, 0, 1, 0);
    tick();
    chk("t6_det", a_det, 1);
    #2 reset = 1'b0;
    #1 check_zero("t6_det_rst");
    m_reset();
    @(negedge clock);
    reset = 1'b1;

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      d    = 8'($urandom);
      d[0] = ($urandom_range(0, 3) != 0);
      d[4] = ($urandom_range(0, 3) != 0);
      set_in(($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom_range(1, 7)),
             2'($urandom_range(0, 3)), d,
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 19) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end

endmodule
